// File: rtl/jtag_tap.sv
// IEEE 1149.1 test access port: 16-state TAP controller, instruction register,
// boundary-scan, IDCODE and bypass data registers, all clocked by TCK.
module jtag_tap #(
  parameter int          IR_W   = 4,
  parameter int          BS_LEN = 8,
  parameter logic [31:0] IDCODE = 32'h1234_5001
) (
  input  logic              TCK,
  input  logic              TRST_N,
  input  logic              TMS,
  input  logic              TDI,
  output logic              TDO,
  output logic              TDO_EN,
  input  logic [BS_LEN-1:0] pin_in,
  output logic [BS_LEN-1:0] pin_out,
  output logic              bs_en,
  output logic [3:0]        state,
  output logic [IR_W-1:0]   inst
);

  generate
    if (IR_W < 2 || IR_W > 8) begin : g_bad_ir_w
      $error("jtag_tap: IR_W must be within 2..8");
    end
    if (BS_LEN < 1 || BS_LEN > 64) begin : g_bad_bs_len
      $error("jtag_tap: BS_LEN must be within 1..64");
    end
    if (IDCODE[0] != 1'b1) begin : g_bad_idcode
      $error("jtag_tap: IDCODE bit 0 must be 1");
    end
  endgenerate

  localparam logic [IR_W-1:0] INST_EXTEST  = '0;
  localparam logic [IR_W-1:0] INST_SAMPLE  = IR_W'(1);
  localparam logic [IR_W-1:0] INST_IDCODE  = IR_W'(2);
  localparam logic [IR_W-1:0] IR_CAPTURE   = IR_W'(1);

  typedef enum logic [3:0] {
    ST_EX2_DR   = 4'h0,
    ST_EX1_DR   = 4'h1,
    ST_SH_DR    = 4'h2,
    ST_PAUSE_DR = 4'h3,
    ST_SEL_IR   = 4'h4,
    ST_UPD_DR   = 4'h5,
    ST_CAP_DR   = 4'h6,
    ST_SEL_DR   = 4'h7,
    ST_EX2_IR   = 4'h8,
    ST_EX1_IR   = 4'h9,
    ST_SH_IR    = 4'hA,
    ST_PAUSE_IR = 4'hB,
    ST_RTI      = 4'hC,
    ST_UPD_IR   = 4'hD,
    ST_CAP_IR   = 4'hE,
    ST_TLR      = 4'hF
  } tap_state_e;

  tap_state_e        state_q, state_d;
  logic [IR_W-1:0]   ir_sr_q;
  logic [IR_W-1:0]   inst_q;
  logic [BS_LEN-1:0] bsr_sr_q;
  logic [BS_LEN-1:0] bsr_upd_q;
  logic [31:0]       id_sr_q;
  logic              byp_q;

  logic              sel_bsr;
  logic              sel_id;
  logic              dr_tdo;
  logic [BS_LEN-1:0] bsr_shift;

  // TAP controller
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      state_q <= ST_TLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_TLR:      state_d = TMS ? ST_TLR      : ST_RTI;
      ST_RTI:      state_d = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_d = TMS ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_d = TMS ? ST_EX1_DR   : ST_SH_DR;
      ST_SH_DR:    state_d = TMS ? ST_EX1_DR   : ST_SH_DR;
      ST_EX1_DR:   state_d = TMS ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = TMS ? ST_EX2_DR   : ST_PAUSE_DR;
      ST_EX2_DR:   state_d = TMS ? ST_UPD_DR   : ST_SH_DR;
      ST_UPD_DR:   state_d = TMS ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_d = TMS ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_d = TMS ? ST_EX1_IR   : ST_SH_IR;
      ST_SH_IR:    state_d = TMS ? ST_EX1_IR   : ST_SH_IR;
      ST_EX1_IR:   state_d = TMS ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = TMS ? ST_EX2_IR   : ST_PAUSE_IR;
      ST_EX2_IR:   state_d = TMS ? ST_UPD_IR   : ST_SH_IR;
      ST_UPD_IR:   state_d = TMS ? ST_SEL_DR   : ST_RTI;
      default:     state_d = ST_TLR;
    endcase
  end

  // Instruction decode: every code other than EXTEST/SAMPLE/IDCODE is bypass
  assign sel_bsr = (inst_q == INST_EXTEST) || (inst_q == INST_SAMPLE);
  assign sel_id  = (inst_q == INST_IDCODE);

  always_comb begin
    bsr_shift            = bsr_sr_q >> 1;
    bsr_shift[BS_LEN-1]  = TDI;
  end

  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      ir_sr_q   <= '0;
      bsr_sr_q  <= '0;
      bsr_upd_q <= '0;
      id_sr_q   <= IDCODE;
      byp_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_CAP_DR: begin
          bsr_sr_q <= pin_in;
          id_sr_q  <= IDCODE;
          byp_q    <= 1'b0;
        end
        ST_SH_DR: begin
          if (sel_bsr) begin
            bsr_sr_q <= bsr_shift;
          end else if (sel_id) begin
            id_sr_q <= {TDI, id_sr_q[31:1]};
          end else begin
            byp_q <= TDI;
          end
        end
        ST_UPD_DR: begin
          if (sel_bsr) begin
            bsr_upd_q <= bsr_sr_q;
          end
        end
        ST_CAP_IR: ir_sr_q <= IR_CAPTURE;
        ST_SH_IR:  ir_sr_q <= {TDI, ir_sr_q[IR_W-1:1]};
        default: ;
      endcase
    end
  end

  // Entering or sitting in TLR forces IDCODE, taking priority over any update
  always_ff @(posedge TCK or negedge TRST_N) begin
    if (!TRST_N) begin
      inst_q <= INST_IDCODE;
    end else if (state_q == ST_TLR || state_d == ST_TLR) begin
      inst_q <= INST_IDCODE;
    end else if (state_q == ST_UPD_IR) begin
      inst_q <= ir_sr_q;
    end
  end

  always_comb begin
    if (sel_bsr) begin
      dr_tdo = bsr_sr_q[0];
    end else if (sel_id) begin
      dr_tdo = id_sr_q[0];
    end else begin
      dr_tdo = byp_q;
    end
  end

  always_comb begin
    TDO_EN = 1'b0;
    TDO    = 1'b0;
    if (state_q == ST_SH_DR) begin
      TDO_EN = 1'b1;
      TDO    = dr_tdo;
    end else if (state_q == ST_SH_IR) begin
      TDO_EN = 1'b1;
      TDO    = ir_sr_q[0];
    end
  end

  assign bs_en   = (inst_q == INST_EXTEST);
  assign pin_out = bs_en ? bsr_upd_q : pin_in;
  assign state   = state_q;
  assign inst    = inst_q;

endmodule

// File: doc/jtag_tap.md
JTAG_TAP -- requirements
Module: jtag_tap

Interface
REQ-001 Parameter IR_W, default 4, instruction register width; legal range 2..8.
REQ-002 Parameter BS_LEN, default 8, number of boundary-scan cells; legal range 1..64.
REQ-003 Parameter IDCODE, default 32'h1234_5001, device ID value; bit 0 SHALL be 1.
REQ-004 TCK  input  1  sole clock; all state changes occur on the rising edge.
REQ-005 TRST_N  input  1  asynchronous, active-low reset.
REQ-006 TMS  input  1  TAP mode select, sampled on the rising edge of TCK.
REQ-007 TDI  input  1  serial scan data in, sampled on the rising edge of TCK.
REQ-008 TDO  output  1  serial scan data out.
REQ-009 TDO_EN  output  1  high while TDO carries valid shift data.
REQ-010 pin_in  input  BS_LEN  system/core data into the boundary cells.
REQ-011 pin_out  output  BS_LEN  data driven to the pins.
REQ-012 bs_en  output  1  high when the boundary update latches drive pin_out.
REQ-013 state  output  4  current TAP state code.
REQ-014 inst  output  IR_W  active (updated) instruction.

Function
REQ-015 The TAP FSM SHALL implement the 16 IEEE 1149.1 states with these state codes: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.
REQ-016 Transitions SHALL follow IEEE 1149.1 as a function of TMS; five consecutive TMS=1 edges SHALL reach TLR from any state.
REQ-017 Register actions SHALL occur on the rising TCK edge taken while the FSM is in the named state (CapDR, ShDR, UpdDR, CapIR, ShIR, UpdIR).
REQ-018 Instruction decode:
  - EXTEST = all zeros
  - SAMPLE = 1
  - IDCODE = 2
  - BYPASS = all ones
  - any other code SHALL decode as BYPASS.
REQ-019 The selected data register SHALL be:
  - BSR shift stage (BS_LEN bits) for EXTEST and SAMPLE
  - 32-bit ID register for IDCODE
  - 1-bit bypass register otherwise.
REQ-020 CapDR loads:
  - BSR shift stage <= pin_in
  - ID register <= IDCODE
  - bypass <= 0.
REQ-021 ShDR: the selected register SHALL shift right by one, with TDI entering the MSB; the pre-shift LSB is the bit on TDO.
REQ-022 UpdDR: BSR update latches SHALL load the BSR shift stage, but only when inst is EXTEST or SAMPLE; otherwise the latches hold.
REQ-023 CapIR: the IR shift stage SHALL load {(IR_W-2){0}, 2'b01}.
REQ-024 ShIR: the IR shift stage SHALL shift right, with TDI entering the MSB.
REQ-025 UpdIR: inst SHALL load the IR shift stage.
REQ-026 Entering TLR, or any edge taken while in TLR, SHALL set inst to IDCODE.
REQ-027 TDO SHALL be the LSB of the selected DR in ShDR and the LSB of the IR shift stage in ShIR; TDO is combinational from registers.
REQ-028 TDO_EN SHALL be 1 in ShDR or ShIR and 0 elsewhere; TDO SHALL be 0 when TDO_EN=0.
REQ-029 bs_en SHALL be 1 when inst==EXTEST, else 0; pin_out = bs_en ? update latches : pin_in.
REQ-030 Pause and exit states SHALL hold all register contents.
REQ-031 Shift length is unbounded; bits shifted beyond the register length SHALL emerge on TDO in order.

Reset
REQ-032 TRST_N=0 SHALL immediately, independent of TCK, force:
  - state=TLR
  - inst=IDCODE
  - IR shift stage, BSR shift stage, update latches and bypass register to 0
  - bs_en=0, TDO_EN=0, TDO=0.
REQ-033 Assertion of TRST_N in any state, including mid-shift, SHALL abort the operation with no update of latches or inst; release SHALL be clean, with the first TCK edge after release evaluated from TLR.

Verification
REQ-034 From ShDR, apply TMS=1 for 5 edges -> state=F; inst=2.
REQ-035 After reset, apply TMS 0,1,0,0 then 32 ShDR edges (TMS=0, last TMS=1) -> TDO shows 0x1234_5001 LSB first, with TDO_EN=1 throughout the shift.
REQ-036 Load IR=4'hF, then shift DR with TDI pattern 1,0,1,1 -> TDO = 0,1,0,1 (one-cycle bypass delay, captured 0 first).
REQ-037 Load IR=4'h0, shift 8'hA5, pass UpdDR -> pin_out=8'hA5, bs_en=1; a change on pin_in does not alter pin_out.
REQ-038 Load IR=4'h1 with pin_in=8'h3C, then CapDR/ShDR 8 edges -> TDO = 0,0,1,1,1,1,0,0; pin_out tracks pin_in; bs_en=0.
REQ-039 With EXTEST active and pin_out=8'hA5, assert TRST_N=0 mid-ShDR -> state=F, inst=2, bs_en=0, pin_out=pin_in, all without a TCK edge.
REQ-040 Shift IR with 4'h7 (undefined) -> DR path is the 1-bit bypass; captured IR value read out while shifting IR is 4'b0001.
